// File: rtl/cook_controller.sv
// cook_controller: microwave cook timer FSM with BCD MM:SS countdown, pause and done alert.
// Optional feature macro: QUICK_START_EN (start at 0000 loads 30 s; start while cooking adds 30 s).
`default_nettype none

module cook_controller #(
  parameter int DONE_SECS = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        startn,
  input  logic        stopn,
  input  logic        door_closed,
  input  logic [3:0]  bcd_in,
  input  logic        loadn,
  input  logic        pgt_1hz,
  output logic        enablen,
  output logic        mag_on,
  output logic [15:0] time_bcd,
  output logic        done
);

  localparam int CNT_W = (DONE_SECS < 2) ? 1 : $clog2(DONE_SECS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_SECS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic             startn_q, stopn_q, loadn_q, tick_q, armed_q;
  logic [15:0]      time_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_ev, stop_ev, key_ev, tick_ev;
  logic [15:0]      time_dec_d;

  // armed_q masks the first edge after reset so levels held through reset never look like events.
  assign start_ev = armed_q & startn_q & ~startn;
  assign stop_ev  = armed_q & stopn_q  & ~stopn;
  assign key_ev   = armed_q & loadn_q  & ~loadn;
  assign tick_ev  = armed_q & ~tick_q  & pgt_1hz;

  always_comb begin
    time_dec_d = time_q;
    if (time_q[3:0] != 4'd0) begin
      time_dec_d[3:0] = time_q[3:0] - 4'd1;
    end else begin
      time_dec_d[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) begin
        time_dec_d[7:4] = time_q[7:4] - 4'd1;
      end else begin
        time_dec_d[7:4] = 4'd5;
        if (time_q[11:8] != 4'd0) begin
          time_dec_d[11:8] = time_q[11:8] - 4'd1;
        end else begin
          time_dec_d[11:8]  = 4'd9;
          time_dec_d[15:12] = time_q[15:12] - 4'd1;
        end
      end
    end
  end

`ifdef QUICK_START_EN
  logic [15:0] time_add_d;
  logic [3:0]  sec_tens_sum;

  always_comb begin
    time_add_d   = time_q;
    sec_tens_sum = time_q[7:4] + 4'd3;
    if (sec_tens_sum < 4'd6) begin
      time_add_d[7:4] = sec_tens_sum;
    end else begin
      time_add_d[7:4] = sec_tens_sum - 4'd6;
      if (time_q[15:8] == 8'h99) begin
        time_add_d = 16'h9959;
      end else if (time_q[11:8] == 4'd9) begin
        time_add_d[11:8]  = 4'd0;
        time_add_d[15:12] = time_q[15:12] + 4'd1;
      end else begin
        time_add_d[11:8] = time_q[11:8] + 4'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      loadn_q  <= 1'b1;
      tick_q   <= 1'b0;
      armed_q  <= 1'b0;
      time_q   <= 16'h0000;
      cnt_q    <= '0;
    end else begin
      startn_q <= startn;
      stopn_q  <= stopn;
      loadn_q  <= loadn;
      tick_q   <= pgt_1hz;
      armed_q  <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (stop_ev) begin
            time_q <= 16'h0000;
          end else if (start_ev) begin
            if (door_closed && (time_q != 16'h0000)) begin
              state_q <= S_COOK;
            end
`ifdef QUICK_START_EN
            else if (door_closed) begin
              time_q  <= 16'h0030;
              state_q <= S_COOK;
            end
`endif
          end else if (key_ev && (bcd_in <= 4'd9)) begin
            time_q <= {time_q[11:0], bcd_in};
          end
        end
        S_COOK: begin
          if (!door_closed || stop_ev) begin
            state_q <= S_PAUSE;
          end
`ifdef QUICK_START_EN
          else if (start_ev) begin
            time_q <= time_add_d;
          end
`endif
          else if (tick_ev) begin
            time_q <= time_dec_d;
            if (time_dec_d == 16'h0000) begin
              state_q <= S_DONE;
            end
          end
        end
        S_PAUSE: begin
          if (stop_ev) begin
            time_q  <= 16'h0000;
            state_q <= S_IDLE;
          end else if (start_ev && door_closed) begin
            state_q <= S_COOK;
          end
        end
        S_DONE: begin
          time_q <= 16'h0000;
          if (stop_ev) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (tick_ev) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Magnetron gating uses the live door input so it drops without waiting for an edge.
  assign mag_on   = (state_q == S_COOK) & door_closed;
  assign enablen  = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign time_bcd = time_q;

endmodule

`default_nettype wire

// File: tb/tb_cook_controller.sv
// Directed testbench for cook_controller: key entry, countdown borrows, pause, done, reset, priority.
`default_nettype none

module tb_cook_controller;

  logic        clk = 1'b0;
  logic        resetn, startn, stopn, door_closed, loadn, pgt_1hz;
  logic [3:0]  bcd_in;
  logic        enablen, mag_on, done;
  logic [15:0] time_bcd;

  int vectors = 0;
  int miscompares = 0;

  cook_controller #(.DONE_SECS(3)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn),
    .door_closed(door_closed), .bcd_in(bcd_in), .loadn(loadn), .pgt_1hz(pgt_1hz),
    .enablen(enablen), .mag_on(mag_on), .time_bcd(time_bcd), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; startn = 1'b1; stopn = 1'b1; loadn = 1'b1;
    pgt_1hz = 1'b0; bcd_in = 4'd0; door_closed = 1'b1;
    step(); step();
    resetn = 1'b1;
    step(); step();
  endtask

  task automatic press_key(input logic [3:0] d);
    bcd_in = d; loadn = 1'b0; step();
    loadn = 1'b1; step();
  endtask

  task automatic press_start();
    startn = 1'b0; step();
    startn = 1'b1; step();
  endtask

  task automatic press_stop();
    stopn = 1'b0; step();
    stopn = 1'b1; step();
  endtask

  task automatic tick();
    pgt_1hz = 1'b1; step();
    pgt_1hz = 1'b0; step();
  endtask

  task automatic enter_and_cook(input logic [15:0] t);
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      press_key(t[i*4 +: 4]);
    end
    press_start();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (time_bcd !== 16'h0000) begin miscompares++; $display("FAIL reset_time: got %h exp 0000", time_bcd); end
    vectors++; if (mag_on !== 1'b0) begin miscompares++; $display("FAIL reset_mag: got %b exp 0", mag_on); end
    vectors++; if (enablen !== 1'b0) begin miscompares++; $display("FAIL reset_enablen: got %b exp 0", enablen); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b exp 0", done); end
  endtask

  task automatic test_keys_start();
    do_reset();
    press_key(4'd1); press_key(4'd2); press_key(4'd5);
    vectors++; if (time_bcd !== 16'h0125) begin miscompares++; $display("FAIL keys_125: got %h exp 0125", time_bcd); end
    press_key(4'd12);
    vectors++; if (time_bcd !== 16'h0125) begin miscompares++; $display("FAIL key_invalid: got %h exp 0125", time_bcd); end
    press_start();
    vectors++; if (mag_on !== 1'b1) begin miscompares++; $display("FAIL start_mag: got %b exp 1", mag_on); end
    vectors++; if (enablen !== 1'b1) begin miscompares++; $display("FAIL start_enablen: got %b exp 1", enablen); end
    press_key(4'd7);
    vectors++; if (time_bcd !== 16'h0125) begin miscompares++; $display("FAIL key_in_cook: got %h exp 0125", time_bcd); end
    tick();
    vectors++; if (time_bcd !== 16'h0124) begin miscompares++; $display("FAIL tick_124: got %h exp 0124", time_bcd); end
  endtask

  task automatic test_borrow();
    enter_and_cook(16'h0100);
    tick();
    vectors++; if (time_bcd !== 16'h0059) begin miscompares++; $display("FAIL borrow_0100: got %h exp 0059", time_bcd); end
    enter_and_cook(16'h0090);
    tick();
    vectors++; if (time_bcd !== 16'h0089) begin miscompares++; $display("FAIL dec_0090: got %h exp 0089", time_bcd); end
    enter_and_cook(16'h1000);
    tick();
    vectors++; if (time_bcd !== 16'h0959) begin miscompares++; $display("FAIL borrow_1000: got %h exp 0959", time_bcd); end
  endtask

  task automatic test_pause();
    enter_and_cook(16'h0040);
    door_closed = 1'b0; #1;
    vectors++; if (mag_on !== 1'b0) begin miscompares++; $display("FAIL door_open_mag: got %b exp 0", mag_on); end
    step();
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (time_bcd !== 16'h0040) begin miscompares++; $display("FAIL pause_hold: got %h exp 0040", time_bcd); end
    vectors++; if (enablen !== 1'b1) begin miscompares++; $display("FAIL pause_enablen: got %b exp 1", enablen); end
    door_closed = 1'b1; step();
    vectors++; if (mag_on !== 1'b0) begin miscompares++; $display("FAIL pause_closed_mag: got %b exp 0", mag_on); end
    press_start();
    vectors++; if (mag_on !== 1'b1) begin miscompares++; $display("FAIL resume_mag: got %b exp 1", mag_on); end
    press_stop(); press_stop();
    vectors++; if (time_bcd !== 16'h0000 || enablen !== 1'b0) begin miscompares++; $display("FAIL pause_stop_clear: got %h/%b exp 0000/0", time_bcd, enablen); end
  endtask

  task automatic test_done();
    enter_and_cook(16'h0002);
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL done_set: got %b exp 1", done); end
    vectors++; if (time_bcd !== 16'h0000 || mag_on !== 1'b0) begin miscompares++; $display("FAIL done_time: got %h/%b exp 0000/0", time_bcd, mag_on); end
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL done_held: got %b exp 1", done); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_clear: got %b exp 0", done); end
    vectors++; if (enablen !== 1'b0) begin miscompares++; $display("FAIL done_idle_en: got %b exp 0", enablen); end
  endtask

  task automatic test_reset_mid();
    enter_and_cook(16'h0517);
    vectors++; if (time_bcd !== 16'h0517) begin miscompares++; $display("FAIL mid_loaded: got %h exp 0517", time_bcd); end
    @(posedge clk); #3;
    resetn = 1'b0; #1;
    vectors++; if (time_bcd !== 16'h0000 || mag_on !== 1'b0 || enablen !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got %h/%b/%b exp 0000/0/0", time_bcd, mag_on, enablen);
    end
    loadn = 1'b0; bcd_in = 4'd7;
    step(); step();
    resetn = 1'b1;
    step(); step(); step();
    vectors++; if (time_bcd !== 16'h0000) begin miscompares++; $display("FAIL no_spurious: got %h exp 0000", time_bcd); end
    loadn = 1'b1; step();
  endtask

  task automatic test_priority();
    do_reset();
    press_key(4'd3);
    press_stop();
    vectors++; if (time_bcd !== 16'h0000) begin miscompares++; $display("FAIL idle_stop: got %h exp 0000", time_bcd); end
    press_key(4'd1); press_key(4'd2);
    bcd_in = 4'd4; loadn = 1'b0; startn = 1'b0; step();
    loadn = 1'b1; startn = 1'b1; step();
    vectors++; if (time_bcd !== 16'h0012 || enablen !== 1'b1) begin miscompares++; $display("FAIL start_over_key: got %h/%b exp 0012/1", time_bcd, enablen); end
    stopn = 1'b0; pgt_1hz = 1'b1; step();
    stopn = 1'b1; pgt_1hz = 1'b0; step();
    vectors++; if (time_bcd !== 16'h0012 || mag_on !== 1'b0) begin miscompares++; $display("FAIL stop_over_tick: got %h/%b exp 0012/0", time_bcd, mag_on); end
  endtask

`ifdef QUICK_START_EN
  task automatic test_quick_start();
    do_reset();
    press_start();
    vectors++; if (time_bcd !== 16'h0030 || mag_on !== 1'b1) begin miscompares++; $display("FAIL qs_idle: got %h/%b exp 0030/1", time_bcd, mag_on); end
    enter_and_cook(16'h9945);
    press_start();
    vectors++; if (time_bcd !== 16'h9959) begin miscompares++; $display("FAIL qs_saturate: got %h exp 9959", time_bcd); end
    enter_and_cook(16'h0045);
    press_start();
    vectors++; if (time_bcd !== 16'h0115) begin miscompares++; $display("FAIL qs_carry: got %h exp 0115", time_bcd); end
  endtask
`else
  task automatic test_no_quick_start();
    do_reset();
    press_start();
    vectors++; if (enablen !== 1'b0 || time_bcd !== 16'h0000) begin miscompares++; $display("FAIL start_at_zero: got %b/%h exp 0/0000", enablen, time_bcd); end
    enter_and_cook(16'h0045);
    press_start();
    vectors++; if (time_bcd !== 16'h0045 || mag_on !== 1'b1) begin miscompares++; $display("FAIL start_in_cook: got %h/%b exp 0045/1", time_bcd, mag_on); end
  endtask
`endif

  initial begin
    resetn = 1'b0; startn = 1'b1; stopn = 1'b1; loadn = 1'b1;
    pgt_1hz = 1'b0; bcd_in = 4'd0; door_closed = 1'b1;
    test_reset();
    test_keys_start();
    test_borrow();
    test_pause();
    test_done();
    test_reset_mid();
    test_priority();
`ifdef QUICK_START_EN
    test_quick_start();
`else
    test_no_quick_start();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
